// File: rtl/wb_reg_slave_if.sv
// wb_reg_slave_if: Wishbone classic bus (8-bit address, 32-bit data) between host master and register slave
// Signals: adr/dat_i/we/stb/cyc driven by the master; dat_o/ack driven by the slave
interface wb_reg_slave_if;
    logic [7:0]  adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;
    modport master (output adr, dat_i, we, stb, cyc, input dat_o, ack);
    modport slave  (input adr, dat_i, we, stb, cyc, output dat_o, ack);
endinterface

// File: rtl/wb_reg_slave.sv
// wb_reg_slave: Wishbone classic register slave with wait states and masked, latched event interrupts
// Ports: wb_clk bus clock; wb_rst_n async active-low reset; bus Wishbone slave modport
// (adr/dat_i/we/stb/cyc in, dat_o/ack out); evt_i event pulses; intr registered interrupt; ctrl_o CTRL contents
module wb_reg_slave #(
    parameter int          WAIT_STATES = 0,
    parameter int          NUM_EVT     = 8,
    parameter logic [31:0] ID_VALUE    = 32'hE7A0_0001
) (
    input  logic               wb_clk,
    input  logic               wb_rst_n,
    wb_reg_slave_if.slave      bus,
    input  logic [NUM_EVT-1:0] evt_i,
    output logic               intr,
    output logic [31:0]        ctrl_o
);
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    state_t             state;
    logic [3:0]         cnt;
    logic [NUM_EVT-1:0] int_src;
    logic [NUM_EVT-1:0] int_mask;
    logic [NUM_EVT-1:0] w1c;
    logic [31:0]        scratch;
    logic [31:0]        rd_data;
    logic [5:0]         word;
    logic               req;
    logic               wr;
    logic               unused;
    assign req     = bus.cyc & bus.stb;
    assign word    = bus.adr[7:2];
    assign unused  = ^bus.adr[1:0];
    // ack is the registered ACK state qualified by the live strobe, so a master
    // that withdraws its strobe never sees (or commits) a stale acknowledge
    assign bus.ack = (state == ACK) & req;
    assign wr      = bus.ack & bus.we;
    assign w1c     = (wr && word == 6'd1) ? bus.dat_i[NUM_EVT-1:0] : '0;
    always_comb
        rd_data = word == 6'd0 ? ctrl_o :
                  word == 6'd1 ? 32'(int_src) :
                  word == 6'd2 ? 32'(int_mask) :
                  word == 6'd3 ? scratch :
                  word == 6'd4 ? ID_VALUE : '0;
    assign bus.dat_o = bus.ack ? rd_data : '0;
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state <= (WAIT_STATES == 0) ? ACK : WAIT;
                    cnt   <= CNT_LOAD;
                end
                WAIT: if (!req) state <= IDLE;
                      else if (cnt == 4'd0) state <= ACK;
                      else cnt <= cnt - 4'd1;
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ctrl_o   <= '0;
            int_src  <= '0;
            int_mask <= '0;
            scratch  <= '0;
            intr     <= 1'b0;
        end else begin
            if (wr && word == 6'd0) ctrl_o <= bus.dat_i;
            if (wr && word == 6'd2) int_mask <= bus.dat_i[NUM_EVT-1:0];
            if (wr && word == 6'd3) scratch <= bus.dat_i;
            // OR-ing evt_i after the clear makes a same-cycle event win over W1C
            int_src <= (int_src & ~w1c) | evt_i;
            intr    <= |(int_src & int_mask);
        end
    end
endmodule

// File: tb/tb_wb_reg_slave.sv
// tb_wb_reg_slave: table-driven and randomized bench for two wb_reg_slave instances (0 and 3 wait states)
module tb_wb_reg_slave;
    logic wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;
    logic [1:0]       rst_n, cyc, stb, we;
    logic [1:0][7:0]  adr, evt;
    logic [1:0][31:0] dat_i;
    wire  [1:0]       ack, intr;
    wire  [1:0][31:0] dat_o, ctrl;
    wb_reg_slave_if b0 ();
    wb_reg_slave_if b1 ();
    assign b0.adr = adr[0];
    assign b0.dat_i = dat_i[0];
    assign b0.we = we[0];
    assign b0.stb = stb[0];
    assign b0.cyc = cyc[0];
    assign ack[0] = b0.ack;
    assign dat_o[0] = b0.dat_o;
    assign b1.adr = adr[1];
    assign b1.dat_i = dat_i[1];
    assign b1.we = we[1];
    assign b1.stb = stb[1];
    assign b1.cyc = cyc[1];
    assign ack[1] = b1.ack;
    assign dat_o[1] = b1.dat_o;
    wb_reg_slave #(.WAIT_STATES(0)) u0 (.wb_clk(wb_clk), .wb_rst_n(rst_n[0]), .bus(b0), .evt_i(evt[0]), .intr(intr[0]), .ctrl_o(ctrl[0]));
    wb_reg_slave #(.WAIT_STATES(3)) u3 (.wb_clk(wb_clk), .wb_rst_n(rst_n[1]), .bus(b1), .evt_i(evt[1]), .intr(intr[1]), .ctrl_o(ctrl[1]));
    int checks = 0;
    int errors = 0;
    logic mon_en;
    logic [1:0][31:0] m_ctrl, m_scr, p_dat;
    logic [1:0][7:0]  m_src, m_mask, p_adr;
    logic [1:0]       m_intr, p_v, p_we;
    typedef struct {
        int          d;
        logic        w;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t tv[$];
    logic [7:0] pick [7];
    function automatic int ws(int d);
        return d ? 3 : 0;
    endfunction
    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask
    // Register file model: committed write of the acked transfer, sticky events, W1C losing to a same-cycle event
    always @(posedge wb_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) begin
                m_ctrl[d] <= '0;
                m_scr[d] <= '0;
                m_src[d] <= '0;
                m_mask[d] <= '0;
                m_intr[d] <= 1'b0;
            end else begin
                if (p_v[d] && p_we[d]) begin
                    case (p_adr[d][7:2])
                        6'd0: m_ctrl[d] <= p_dat[d];
                        6'd2: m_mask[d] <= p_dat[d][7:0];
                        6'd3: m_scr[d] <= p_dat[d];
                        default: ;
                    endcase
                end
                m_src[d] <= (m_src[d] & ~((p_v[d] && p_we[d] && p_adr[d][7:2] == 6'd1) ? p_dat[d][7:0] : 8'h00)) | evt[d];
                m_intr[d] <= |(m_src[d] & m_mask[d]);
            end
        end
    end
    function automatic logic [31:0] mread(int d, logic [7:0] a);
        case (a[7:2])
            6'd0: return m_ctrl[d];
            6'd1: return {24'h0, m_src[d]};
            6'd2: return {24'h0, m_mask[d]};
            6'd3: return m_scr[d];
            6'd4: return 32'hE7A0_0001;
            default: return 32'h0;
        endcase
    endfunction
    always @(negedge wb_clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (rst_n[d]) begin
                    chk("intr_model", 32'(intr[d]), 32'(m_intr[d]));
                    chk("ctrl_model", ctrl[d], m_ctrl[d]);
                end
            end
        end
    end
    task automatic xfer(input int d, input logic w, input logic [7:0] a, input logic [31:0] wd, output logic [31:0] rd);
        int n;
        chk("dat_o_before", dat_o[d], 32'h0);
        adr[d] = a;
        we[d] = w;
        dat_i[d] = wd;
        cyc[d] = 1'b1;
        stb[d] = 1'b1;
        n = 0;
        do begin
            @(negedge wb_clk);
            n++;
            if (!ack[d]) chk("dat_o_wait", dat_o[d], 32'h0);
        end while (!ack[d] && n < 40);
        chk("ack_latency", 32'(n), 32'(ws(d) + 1));
        rd = dat_o[d];
        if (!w) chk("read_model", rd, mread(d, a));
        p_v[d] = ack[d];
        p_we[d] = w;
        p_adr[d] = a;
        p_dat[d] = wd;
        @(negedge wb_clk);
        p_v[d] = 1'b0;
        chk("ack_after", 32'(ack[d]), 32'h0);
        chk("dat_o_after", dat_o[d], 32'h0);
        cyc[d] = 1'b0;
        stb[d] = 1'b0;
    endtask
    task automatic add(int d, logic w, logic [7:0] a, logic [31:0] wd, logic [31:0] e);
        vec_t v;
        v.d = d;
        v.w = w;
        v.a = a;
        v.wd = wd;
        v.exp = e;
        tv.push_back(v);
    endtask
    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] rd;
        logic [7:0]  a;
        int          d;
        pick = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h40, 8'hFC};
        rst_n = 2'b00; cyc = '0; stb = '0; we = '0; adr = '0; dat_i = '0; evt = '0;
        p_v = '0; p_we = '0; p_adr = '0; p_dat = '0; mon_en = 1'b0;
        add(0, 0, 8'h10, 0, 32'hE7A0_0001);
        add(0, 1, 8'h00, 32'hDEAD_BEEF, 0);
        add(0, 0, 8'h00, 0, 32'hDEAD_BEEF);
        add(0, 1, 8'h0C, 32'h1234_5678, 0);
        add(0, 0, 8'h0C, 0, 32'h1234_5678);
        add(0, 1, 8'h40, 32'hFFFF_FFFF, 0);
        add(0, 0, 8'h40, 0, 32'h0);
        add(0, 0, 8'h00, 0, 32'hDEAD_BEEF);
        add(0, 0, 8'h0E, 0, 32'h1234_5678);
        add(0, 0, 8'h08, 0, 32'h0);
        add(0, 1, 8'h08, 32'hFFFF_FF05, 0);
        add(0, 0, 8'h08, 0, 32'h0000_0005);
        add(0, 1, 8'h10, 32'h0, 0);
        add(0, 0, 8'h10, 0, 32'hE7A0_0001);
        add(0, 0, 8'h04, 0, 32'h0);
        add(1, 1, 8'h0C, 32'hCAFE_F00D, 0);
        add(1, 0, 8'h0C, 0, 32'hCAFE_F00D);
        add(1, 1, 8'h00, 32'hA5A5_A5A5, 0);
        add(1, 0, 8'h10, 0, 32'hE7A0_0001);
        repeat (3) @(negedge wb_clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ack", 32'(ack[i]), 32'h0);
            chk("rst_dat_o", dat_o[i], 32'h0);
            chk("rst_intr", 32'(intr[i]), 32'h0);
            chk("rst_ctrl", ctrl[i], 32'h0);
        end
        rst_n = 2'b11;
        mon_en = 1'b1;
        @(negedge wb_clk);
        for (int i = 0; i < tv.size(); i++) begin
            xfer(tv[i].d, tv[i].w, tv[i].a, tv[i].wd, rd);
            if (!tv[i].w) chk("vec_read", rd, tv[i].exp);
            if (tv[i].w && tv[i].a == 8'h00) chk("vec_ctrl_o", ctrl[tv[i].d], tv[i].wd);
        end
        stb[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk);
            chk("stb_no_cyc", 32'(ack[0]), 32'h0);
        end
        stb[0] = 1'b0;
        @(negedge wb_clk);
        evt[0] = 8'h04;
        @(negedge wb_clk);
        evt[0] = 8'h00;
        chk("intr_early", 32'(intr[0]), 32'h0);
        @(negedge wb_clk);
        chk("intr_set", 32'(intr[0]), 32'h1);
        xfer(0, 0, 8'h04, 0, rd);
        chk("src_04", rd, 32'h04);
        xfer(0, 1, 8'h04, 32'h04, rd);
        @(negedge wb_clk);
        chk("intr_w1c", 32'(intr[0]), 32'h0);
        evt[0] = 8'h02;
        @(negedge wb_clk);
        evt[0] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk);
            chk("intr_masked", 32'(intr[0]), 32'h0);
        end
        xfer(0, 0, 8'h04, 0, rd);
        chk("src_02", rd, 32'h02);
        evt[0] = 8'h01;
        @(negedge wb_clk);
        evt[0] = 8'h00;
        @(negedge wb_clk);
        chk("intr_bit0", 32'(intr[0]), 32'h1);
        evt[0] = 8'h01;
        xfer(0, 1, 8'h04, 32'h01, rd);
        evt[0] = 8'h00;
        repeat (2) @(negedge wb_clk);
        chk("set_wins_intr", 32'(intr[0]), 32'h1);
        xfer(0, 0, 8'h04, 0, rd);
        chk("set_wins_src", rd, 32'h03);
        xfer(0, 1, 8'h08, 32'h0, rd);
        @(negedge wb_clk);
        chk("intr_unmask", 32'(intr[0]), 32'h0);
        adr[1] = 8'h0C; we[1] = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
        @(negedge wb_clk);
        chk("abort_wait1", 32'(ack[1]), 32'h0);
        @(negedge wb_clk);
        stb[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge wb_clk);
            chk("abort_no_ack", 32'(ack[1]), 32'h0);
        end
        cyc[1] = 1'b0;
        xfer(1, 1, 8'h00, 32'h1111_2222, rd);
        chk("after_abort_ctrl", ctrl[1], 32'h1111_2222);
        adr[1] = 8'h00; we[1] = 1'b1; dat_i[1] = 32'h55AA_55AA; cyc[1] = 1'b1; stb[1] = 1'b1;
        repeat (2) @(negedge wb_clk);
        rst_n[1] = 1'b0;
        #1;
        chk("rst_async_ctrl", ctrl[1], 32'h0);
        chk("rst_async_ack", 32'(ack[1]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk);
            chk("rst_mid_ack", 32'(ack[1]), 32'h0);
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        rst_n[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk);
            chk("rst_mid_noack", 32'(ack[1]), 32'h0);
        end
        chk("rst_mid_ctrl", ctrl[1], 32'h0);
        for (int i = 0; i < 200; i++) begin
            d = i % 2;
            evt[d] = 8'($urandom) & 8'($urandom);
            @(negedge wb_clk);
            evt[d] = 8'h00;
            a = pick[$urandom_range(0, 6)] | 8'($urandom_range(0, 3));
            xfer(d, 1'($urandom), a, $urandom, rd);
        end
        repeat (3) @(negedge wb_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
